// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared state encoding, defaults and register-select helper for the crossbar loader
// Contents: ST_* state codes, DEF_DATA_W / DEF_NREGS defaults, rin_bit() one-hot bit decode.
package crossbar_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREGS  = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_FLUSH = 3'd2;
    localparam state_t ST_SWAP  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    typedef logic [7:0] idx_t;

    // Register numbers are 1-based: index 0 selects R1. Every user of RinExt
    // goes through this so the bit order cannot drift between blocks.
    function automatic logic rin_bit(input idx_t idx, input int reg_num);
        return (int'(idx) + 1) == reg_num;
    endfunction

endpackage

// File: rtl/crossbar_onehot.sv
// rtl/crossbar_onehot.sv - combinational index to [1:NREGS] one-hot register select
// Ports: idx (in, IDX_W) zero-based register index; sel (out, [1:NREGS]) one-hot, bit 1 = R1.
module crossbar_onehot
    import crossbar_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx,
    output logic [1:NREGS]   sel
);

    always_comb begin
        sel = '0;
        for (int i = 1; i <= NREGS; i++) begin
            sel[i] = rin_bit(idx_t'(idx), i);
        end
    end

endmodule

// File: rtl/crossbar_loader.sv
// rtl/crossbar_loader.sv - sequencer loading R1..RN of the crossbar from a byte stream, then pulsing w
// Ports: Clock, Reset (sync, active-high); Start; InData/InValid/InReady byte input handshake;
//        Data/Extern/RinExt registered external-load drive; w registered transfer request;
//        Busy (LOAD/FLUSH/SWAP); Done one-cycle completion pulse.
module crossbar_loader
    import crossbar_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NREGS       = DEF_NREGS,
    parameter int SWAP_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [DATA_W-1:0] Data,
    output logic              Extern,
    output logic [1:NREGS]    RinExt,
    output logic              w,
    output logic              Busy,
    output logic              Done
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       swap_cnt;
    logic [1:NREGS]   sel;
    logic             handshake;
    logic             last_load;
    logic             last_swap;

    crossbar_onehot #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_onehot (
        .idx (idx),
        .sel (sel)
    );

    assign InReady   = (state == ST_LOAD);
    assign Busy      = (state == ST_LOAD) || (state == ST_FLUSH) || (state == ST_SWAP);
    assign Done      = (state == ST_DONE);
    assign handshake = InValid && InReady;
    assign last_load = (idx == IDX_W'(NREGS - 1));
    assign last_swap = (swap_cnt == 4'(SWAP_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            swap_cnt <= '0;
            Data     <= '0;
            Extern   <= 1'b0;
            RinExt   <= '0;
            w        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (handshake) begin
                        Data   <= InData;
                        Extern <= 1'b1;
                        RinExt <= sel;
                        // Leave idx parked on the last register rather than wrapping.
                        if (last_load) begin
                            state <= ST_FLUSH;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        // A stall cycle must not re-load the previous register.
                        Extern <= 1'b0;
                        RinExt <= '0;
                    end
                end
                ST_FLUSH: begin
                    // Last load pulse is on the bus now; drop it before raising w.
                    Extern   <= 1'b0;
                    RinExt   <= '0;
                    w        <= 1'b1;
                    swap_cnt <= '0;
                    state    <= ST_SWAP;
                end
                ST_SWAP: begin
                    if (last_swap) begin
                        w     <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        swap_cnt <= swap_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crossbar_loader.sv
// tb/tb_crossbar_loader.sv - self-checking bench for crossbar_loader (NREGS=4/SWAP=2 and NREGS=2/SWAP=5)
module tb_crossbar_loader;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic Reset;

    logic       a_start, a_valid, a_ready, a_ext, a_w, a_busy, a_done;
    logic [7:0] a_din, a_data;
    logic [1:4] a_rin;

    logic       b_start, b_valid, b_ready, b_ext, b_w, b_busy, b_done;
    logic [7:0] b_din, b_data;
    logic [1:2] b_rin;

    crossbar_loader #(.DATA_W(8), .NREGS(4), .SWAP_CYCLES(2)) u_dut_a (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (a_start),
        .InData  (a_din),
        .InValid (a_valid),
        .InReady (a_ready),
        .Data    (a_data),
        .Extern  (a_ext),
        .RinExt  (a_rin),
        .w       (a_w),
        .Busy    (a_busy),
        .Done    (a_done)
    );

    crossbar_loader #(.DATA_W(8), .NREGS(2), .SWAP_CYCLES(5)) u_dut_b (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (b_start),
        .InData  (b_din),
        .InValid (b_valid),
        .InReady (b_ready),
        .Data    (b_data),
        .Extern  (b_ext),
        .RinExt  (b_rin),
        .w       (b_w),
        .Busy    (b_busy),
        .Done    (b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // {ready, data, extern, rin[1:4], w, busy, done}
    function automatic logic [16:0] pk(input logic r, input logic [7:0] d, input logic e,
                                       input logic [3:0] rin, input logic wv, input logic b,
                                       input logic dn);
        return {r, d, e, rin, wv, b, dn};
    endfunction

    function automatic logic [16:0] a_pack();
        return {a_ready, a_data, a_ext, a_rin, a_w, a_busy, a_done};
    endfunction

    function automatic logic [14:0] b_pack();
        return {b_ready, b_data, b_ext, b_rin, b_w, b_busy, b_done};
    endfunction

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  din;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic v, input logic [7:0] din,
                       input logic r, input logic [7:0] d, input logic e, input logic [3:0] rin,
                       input logic wv, input logic b, input logic dn);
        vec_t t;
        t.start = s;
        t.valid = v;
        t.din   = din;
        t.exp   = pk(r, d, e, rin, wv, b, dn);
        vecs.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, rebusy, k, wcnt, overlap;
        logic [14:0] bexp;

        // Plain transaction CA FE BA BE, InValid always high (ignored outside LOAD).
        add(1,1,8'hCA, 0,8'h00,0,4'b0000,0,0,0);
        add(0,1,8'hCA, 1,8'h00,0,4'b0000,0,1,0);
        add(0,1,8'hFE, 1,8'hCA,1,4'b1000,0,1,0);
        add(0,1,8'hBA, 1,8'hFE,1,4'b0100,0,1,0);
        add(0,1,8'hBE, 1,8'hBA,1,4'b0010,0,1,0);
        add(0,1,8'h00, 0,8'hBE,1,4'b0001,0,1,0);
        add(0,1,8'h00, 0,8'hBE,0,4'b0000,1,1,0);
        add(0,1,8'h00, 0,8'hBE,0,4'b0000,1,1,0);
        add(0,1,8'h00, 0,8'hBE,0,4'b0000,0,0,1);
        // IDLE, Data retained; start the stalled transaction.
        add(1,1,8'hCA, 0,8'hBE,0,4'b0000,0,0,0);
        add(0,1,8'hCA, 1,8'hBE,0,4'b0000,0,1,0);
        add(0,1,8'hFE, 1,8'hCA,1,4'b1000,0,1,0);
        add(0,0,8'hFE, 1,8'hFE,1,4'b0100,0,1,0);
        add(0,0,8'h00, 1,8'hFE,0,4'b0000,0,1,0);
        add(0,0,8'h00, 1,8'hFE,0,4'b0000,0,1,0);
        add(0,1,8'hBA, 1,8'hFE,0,4'b0000,0,1,0);
        add(0,1,8'hBE, 1,8'hBA,1,4'b0010,0,1,0);
        add(0,0,8'h00, 0,8'hBE,1,4'b0001,0,1,0);
        add(0,0,8'h00, 0,8'hBE,0,4'b0000,1,1,0);
        add(0,0,8'h00, 0,8'hBE,0,4'b0000,1,1,0);
        add(0,0,8'h00, 0,8'hBE,0,4'b0000,0,0,1);
        add(0,0,8'h00, 0,8'hBE,0,4'b0000,0,0,0);

        Reset   = 1'b1;
        a_start = 0; a_valid = 0; a_din = 8'h00;
        b_start = 0; b_valid = 0; b_din = 8'h00;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check("reset_a", 32'(a_pack()), 32'(pk(0,8'h00,0,4'b0000,0,0,0)));
        check("reset_b", 32'(b_pack()), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_start = vecs[i].start;
            a_valid = vecs[i].valid;
            a_din   = vecs[i].din;
            check($sformatf("vec%0d", i), 32'(a_pack()), 32'(vecs[i].exp));
            @(negedge Clock);
        end
        a_start = 0; a_valid = 0;

        // Start pulsed during SWAP has no effect.
        a_start = 1; a_valid = 1; a_din = 8'h33;
        @(negedge Clock);
        a_start = 0;
        k = 0;
        while (!a_w && k < 20) begin @(negedge Clock); k++; end
        check("swap_reached", 32'(a_w), 32'd1);
        a_start = 1;
        @(negedge Clock);
        a_start = 0;
        dn = 0; rebusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_done) dn++;
            if (dn > 0 && !a_done && (a_busy || a_ready)) rebusy++;
            @(negedge Clock);
        end
        check("swap_start_done_count", 32'(dn), 32'd1);
        check("swap_start_no_rerun", 32'(rebusy), 32'd0);
        check("swap_start_idle", 32'({a_busy, a_done, a_ready, a_w}), 32'd0);

        // Reset mid-load, then a fresh transaction starts at R1.
        a_start = 1; a_valid = 1; a_din = 8'h44;
        @(negedge Clock);
        a_start = 0;
        k = 0;
        while (a_rin !== 4'b0010 && k < 20) begin @(negedge Clock); k++; end
        check("rin0010_reached", 32'(a_rin), 32'b0010);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_mid_a", 32'(a_pack()), 32'd0);
        check("reset_mid_b", 32'(b_pack()), 32'd0);
        Reset = 1'b0; a_start = 1; a_din = 8'h5A;
        @(negedge Clock);
        a_start = 0;
        check("post_reset_load", 32'(a_pack()), 32'(pk(1,8'h00,0,4'b0000,0,1,0)));
        @(negedge Clock);
        check("post_reset_r1", 32'(a_pack()), 32'(pk(1,8'h5A,1,4'b1000,0,1,0)));
        k = 0;
        while (!a_done && k < 20) begin @(negedge Clock); k++; end
        check("post_reset_done", 32'(a_done), 32'd1);
        @(negedge Clock);

        // Start held high: exactly one IDLE cycle between transactions.
        a_start = 1; a_valid = 1;
        for (int t = 0; t < 2; t++) begin
            k = 0;
            while (!a_done && k < 30) begin @(negedge Clock); k++; end
            check("held_done", 32'(a_done), 32'd1);
            @(negedge Clock);
            check("held_idle", 32'({a_busy, a_done, a_ready}), 32'd0);
            @(negedge Clock);
            check("held_load", 32'({a_ready, a_busy}), 32'b11);
        end
        a_start = 0;
        k = 0;
        while (!a_done && k < 30) begin @(negedge Clock); k++; end
        @(negedge Clock);

        // NREGS=2, SWAP_CYCLES=5: ready 1..2, pulses 2..3, w 4..8, done 9.
        wcnt = 0; overlap = 0;
        for (int c = 0; c < 15; c++) begin
            b_start = (c == 0);
            b_valid = 1'b1;
            b_din   = (c == 1) ? 8'h11 : (c == 2) ? 8'h22 : 8'hEE;
            bexp = {(c == 1 || c == 2),
                    (c < 2) ? 8'h00 : (c == 2) ? 8'h11 : 8'h22,
                    (c == 2 || c == 3),
                    (c == 2) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00,
                    (c >= 4 && c <= 8),
                    (c >= 1 && c <= 8),
                    (c == 9)};
            check($sformatf("b_cycle%0d", c), 32'(b_pack()), 32'(bexp));
            if (b_w) wcnt++;
            if (b_w && (b_ext || (|b_rin))) overlap++;
            @(negedge Clock);
        end
        b_start = 0;
        check("b_w_cycles", 32'(wcnt), 32'd5);
        check("b_w_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
